// File: rtl/pcie_tlp_pkg.sv
// Shared PCIe TLP definitions for the root-port test path.
// Header field positions assume a 128-bit beat with DW0 in [31:0].
package pcie_tlp_pkg;

    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
    localparam logic [4:0] TYPE_MEM       = 5'b00000;
    localparam logic [4:0] TYPE_CPL       = 5'b01010;

    localparam logic [7:0] MEMRD32 = {FMT_3DW_NODATA, TYPE_MEM};
    localparam logic [7:0] MEMWR32 = {FMT_3DW_DATA, TYPE_MEM};
    localparam logic [7:0] CPL     = {FMT_3DW_NODATA, TYPE_CPL};
    localparam logic [7:0] CPLD    = {FMT_3DW_DATA, TYPE_CPL};

    localparam int FMT_LSB    = 29;
    localparam int TYPE_LSB   = 24;
    localparam int LEN_LSB    = 0;
    localparam int STATUS_LSB = 45;
    localparam int TAG_LSB    = 72;
    localparam int DATA_LSB   = 96;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_STATUS  = 3'd1,
        ERR_TAG     = 3'd2,
        ERR_NODATA  = 3'd3,
        ERR_DATA    = 3'd4,
        ERR_LENGTH  = 3'd5,
        ERR_TIMEOUT = 3'd6
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SOF,
        ST_DATA,
        ST_DRAIN
    } chk_state_e;

    typedef struct packed {
        logic [7:0]  fmt_type;
        logic [9:0]  len;
        logic [2:0]  status;
        logic [7:0]  tag;
        logic [31:0] data;
    } cpl_hdr_t;

    // A length field of zero encodes the maximum payload of 1024 DW.
    function automatic logic [10:0] len_dw(input logic [9:0] len);
        return (len == 10'd0) ? 11'd1024 : {1'b0, len};
    endfunction

endpackage

// File: rtl/rx_sof_tracker.sv
// Tracks TLP framing on an AXI4-Stream RX interface.
// Every TLP starts on a beat boundary, so SOF is the first beat after tlast.
module rx_sof_tracker (
    input  logic user_clk,
    input  logic reset_n,
    input  logic tvalid,
    input  logic tready,
    input  logic tlast,
    output logic is_sof,
    output logic in_tlp,
    output logic in_tlp_next
);

    logic beat;

    assign beat        = tvalid & tready;
    assign is_sof      = beat & ~in_tlp;
    assign in_tlp_next = beat ? ~tlast : in_tlp;

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            in_tlp <= 1'b0;
        end else begin
            in_tlp <= in_tlp_next;
        end
    end

endmodule

// File: rtl/cpl_checker.sv
// Completion checker for the root-port test controller.
// Parses RX completions and reports a registered pass/fail pulse per check.
module cpl_checker
    import pcie_tlp_pkg::*;
#(
    parameter int TCQ            = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic         user_clk,
    input  logic         reset_n,
    input  logic         arm,
    input  logic         rx_type,
    input  logic [7:0]   rx_tag,
    input  logic [31:0]  rx_data,
    input  logic [10:0]  exp_length,
    input  logic [127:0] m_axis_rx_tdata,
    input  logic [15:0]  m_axis_rx_tkeep,
    input  logic         m_axis_rx_tvalid,
    input  logic         m_axis_rx_tlast,
    output logic         m_axis_rx_tready,
    output logic         rx_success,
    output logic         rx_fail,
    output logic [2:0]   err_code,
    output logic         busy
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    // TCQ only shapes simulation timing elsewhere in the controller.
    if (TCQ < 0) begin : g_tcq_range
    end

    chk_state_e  state, state_n;
    err_e        err_q, err_n, hdr_err;
    cpl_hdr_t    hdr;

    logic        tready_q;
    logic        beat, is_sof, in_tlp, in_tlp_next;
    logic        start, timeout, is_cpl;
    logic [7:0]  tag_q;
    logic [31:0] data_q;
    logic [10:0] exp_q;
    logic [11:0] acc, acc_n, sum;
    logic [15:0] timer, timer_n;
    logic        seen, seen_n;
    logic        busy_n, succ_n, fail_n;
    logic        unused_bits;

    assign m_axis_rx_tready = tready_q;
    assign err_code         = err_q;
    assign beat             = m_axis_rx_tvalid & tready_q;
    assign start            = arm & rx_type;
    assign timeout          = busy && (timer == TMO_LAST);
    assign unused_bits      = ^{m_axis_rx_tdata, m_axis_rx_tkeep, in_tlp};

    rx_sof_tracker u_sof (
        .user_clk    (user_clk),
        .reset_n     (reset_n),
        .tvalid      (m_axis_rx_tvalid),
        .tready      (tready_q),
        .tlast       (m_axis_rx_tlast),
        .is_sof      (is_sof),
        .in_tlp      (in_tlp),
        .in_tlp_next (in_tlp_next)
    );

    assign hdr.fmt_type = {m_axis_rx_tdata[FMT_LSB +: 3],
                           m_axis_rx_tdata[TYPE_LSB +: 5]};
    assign hdr.len      = m_axis_rx_tdata[LEN_LSB +: 10];
    assign hdr.status   = m_axis_rx_tdata[STATUS_LSB +: 3];
    assign hdr.tag      = m_axis_rx_tdata[TAG_LSB +: 8];
    assign hdr.data     = m_axis_rx_tdata[DATA_LSB +: 32];

    assign is_cpl = (hdr.fmt_type == CPL) || (hdr.fmt_type == CPLD);
    assign sum    = acc + {1'b0, len_dw(hdr.len)};

    always_comb begin
        if (hdr.status != 3'd0)
            hdr_err = ERR_STATUS;
        else if (hdr.tag != tag_q)
            hdr_err = ERR_TAG;
        else if (hdr.fmt_type == CPL)
            hdr_err = ERR_NODATA;
        else if (!seen && hdr.data != data_q)
            hdr_err = ERR_DATA;
        else if (sum > {1'b0, exp_q})
            hdr_err = ERR_LENGTH;
        else
            hdr_err = ERR_NONE;
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        seen_n  = seen;
        busy_n  = busy;
        err_n   = err_q;
        succ_n  = 1'b0;
        fail_n  = 1'b0;
        timer_n = busy ? timer + 16'd1 : timer;

        unique case (state)
            ST_IDLE: begin
            end
            ST_SOF: begin
                if (is_sof) begin
                    if (!is_cpl) begin
                        if (!m_axis_rx_tlast) state_n = ST_DRAIN;
                    end else if (hdr_err != ERR_NONE) begin
                        fail_n  = 1'b1;
                        err_n   = hdr_err;
                        busy_n  = 1'b0;
                        state_n = m_axis_rx_tlast ? ST_IDLE : ST_DRAIN;
                    end else begin
                        acc_n  = sum;
                        seen_n = 1'b1;
                        if (!m_axis_rx_tlast) begin
                            state_n = ST_DATA;
                        end else if (sum == {1'b0, exp_q}) begin
                            succ_n  = 1'b1;
                            busy_n  = 1'b0;
                            state_n = ST_IDLE;
                        end
                    end
                end else if (beat && !m_axis_rx_tlast) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DATA: begin
                if (beat && m_axis_rx_tlast) begin
                    if (acc == {1'b0, exp_q}) begin
                        succ_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_SOF;
                    end
                end
            end
            ST_DRAIN: begin
                if (beat && m_axis_rx_tlast)
                    state_n = busy ? ST_SOF : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // A result decided on this beat takes precedence over the timer.
        if (timeout && !succ_n && !fail_n) begin
            fail_n  = 1'b1;
            err_n   = ERR_TIMEOUT;
            busy_n  = 1'b0;
            state_n = in_tlp_next ? ST_DRAIN : ST_IDLE;
        end

        if (start) begin
            acc_n   = '0;
            timer_n = '0;
            seen_n  = 1'b0;
            succ_n  = 1'b0;
            fail_n  = 1'b0;
            if (exp_length == 11'd0) begin
                fail_n  = 1'b1;
                err_n   = ERR_LENGTH;
                busy_n  = 1'b0;
                state_n = in_tlp_next ? ST_DRAIN : ST_IDLE;
            end else begin
                err_n   = ERR_NONE;
                busy_n  = 1'b1;
                state_n = in_tlp_next ? ST_DRAIN : ST_SOF;
            end
        end
    end

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            tready_q   <= 1'b0;
            acc        <= '0;
            timer      <= '0;
            seen       <= 1'b0;
            busy       <= 1'b0;
            rx_success <= 1'b0;
            rx_fail    <= 1'b0;
            err_q      <= ERR_NONE;
            tag_q      <= '0;
            data_q     <= '0;
            exp_q      <= '0;
        end else begin
            state      <= state_n;
            tready_q   <= 1'b1;
            acc        <= acc_n;
            timer      <= timer_n;
            seen       <= seen_n;
            busy       <= busy_n;
            rx_success <= succ_n;
            rx_fail    <= fail_n;
            err_q      <= err_n;
            if (start) begin
                tag_q  <= rx_tag;
                data_q <= rx_data;
                exp_q  <= exp_length;
            end
        end
    end

endmodule

// File: tb/tb_cpl_checker.sv
// Randomized bench for cpl_checker against a TLP-level reference model.
// Expected pulses are derived per TLP from the completion rules.
module tb_cpl_checker;
    import pcie_tlp_pkg::*;

    localparam int TMO = 100;

    logic         user_clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         arm = 1'b0;
    logic         rx_type = 1'b0;
    logic [7:0]   rx_tag = '0;
    logic [31:0]  rx_data = '0;
    logic [10:0]  exp_length = '0;
    logic [127:0] tdata = '0;
    logic [15:0]  tkeep = 16'hFFFF;
    logic         tvalid = 1'b0;
    logic         tlast = 1'b0;
    logic         tready;
    logic         rx_success;
    logic         rx_fail;
    logic [2:0]   err_code;
    logic         busy;

    always #5 user_clk = ~user_clk;

    cpl_checker #(.TCQ(1), .TIMEOUT_CYCLES(TMO)) dut (
        .user_clk         (user_clk),
        .reset_n          (reset_n),
        .arm              (arm),
        .rx_type          (rx_type),
        .rx_tag           (rx_tag),
        .rx_data          (rx_data),
        .exp_length       (exp_length),
        .m_axis_rx_tdata  (tdata),
        .m_axis_rx_tkeep  (tkeep),
        .m_axis_rx_tvalid (tvalid),
        .m_axis_rx_tlast  (tlast),
        .m_axis_rx_tready (tready),
        .rx_success       (rx_success),
        .rx_fail          (rx_fail),
        .err_code         (err_code),
        .busy             (busy)
    );

    int n_chk = 0;
    int n_err = 0;

    bit          m_active = 0;
    bit          m_seen = 0;
    int          m_acc = 0;
    int          m_exp = 0;
    int          m_cyc = 0;
    int          m_err = 0;
    logic [7:0]  m_tag = '0;
    logic [31:0] m_data = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic outs(input bit es, input bit ef);
        check("rx_success", {31'd0, rx_success}, {31'd0, es});
        check("rx_fail", {31'd0, rx_fail}, {31'd0, ef});
        check("busy", {31'd0, busy}, {31'd0, m_active});
        check("err_code", {29'd0, err_code}, m_err);
        check("tready", {31'd0, tready}, 32'd1);
    endtask

    task automatic tick(input bit fs, input bit ff, input int code);
        bit es = 0;
        bit ef = 0;
        @(posedge user_clk);
        #1;
        if (m_active) begin
            m_cyc++;
            if (fs) begin
                m_active = 0;
                es = 1;
            end else if (ff) begin
                m_active = 0;
                ef = 1;
                m_err = code;
            end else if (m_cyc >= TMO) begin
                m_active = 0;
                ef = 1;
                m_err = 6;
            end
        end
        outs(es, ef);
    endtask

    task automatic arm_chk(input bit typ, input logic [7:0] tg,
                           input logic [31:0] dw, input int len);
        bit ef = 0;
        arm = 1'b1;
        rx_type = typ;
        rx_tag = tg;
        rx_data = dw;
        exp_length = len[10:0];
        if (!typ) begin
            tick(0, 0, 0);
            arm = 1'b0;
            return;
        end
        @(posedge user_clk);
        #1;
        arm = 1'b0;
        m_cyc = 0;
        m_acc = 0;
        m_seen = 0;
        m_tag = tg;
        m_data = dw;
        m_exp = len;
        if (len == 0) begin
            m_active = 0;
            m_err = 5;
            ef = 1;
        end else begin
            m_active = 1;
            m_err = 0;
        end
        outs(0, ef);
    endtask

    task automatic send_tlp(input logic [7:0] ft, input int len,
                            input logic [2:0] st, input logic [7:0] tg,
                            input logic [31:0] dw, input int abort_at = -1);
        logic [9:0] len10 = len[9:0];
        bit has_data = (ft[7:5] == FMT_3DW_DATA);
        int ndw = 3 + (has_data ? len : 0);
        int nb = (ndw + 3) / 4;
        bit cpl = (ft == CPL) || (ft == CPLD);
        bit good = 0;
        bit fs = 0;
        bit ff = 0;
        int code = 0;
        if (m_active && cpl) begin
            if (st != 3'd0) code = 1;
            else if (tg != m_tag) code = 2;
            else if (ft == CPL) code = 3;
            else if (!m_seen && dw != m_data) code = 4;
            else if (m_acc + len > m_exp) code = 5;
            if (code != 0) begin
                ff = 1;
            end else begin
                good = 1;
                m_acc += len;
                m_seen = 1;
                fs = (nb == 1) && (m_acc == m_exp);
            end
        end
        for (int i = 0; i < nb; i++) begin
            tvalid = 1'b1;
            tlast = (i == nb - 1);
            if (i == 0) begin
                tdata = {dw, 16'h0, tg, 8'h0, 16'h0100, st, 13'h0,
                         ft, 14'h0, len10};
                tick(fs, ff, code);
            end else begin
                tdata = {$urandom, $urandom, $urandom, $urandom};
                tick(good && (i == nb - 1) && (m_acc == m_exp), 0, 0);
            end
            if (i == abort_at) return;
        end
        tvalid = 1'b0;
        tlast = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int r;
        int c;
        int rem;
        #1;
        check("rst_tready", {31'd0, tready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pulses", {30'd0, rx_success, rx_fail}, 32'd0);
        check("rst_err", {29'd0, err_code}, 32'd0);
        #20;
        @(negedge user_clk);
        reset_n = 1'b1;
        @(posedge user_clk);
        #1;
        outs(0, 0);

        arm_chk(1, 8'h05, 32'h12345678, 4);
        send_tlp(CPLD, 4, 0, 8'h05, 32'h12345678);
        tick(0, 0, 0);

        arm_chk(1, 8'h05, 32'h12345678, 4);
        send_tlp(CPLD, 2, 0, 8'h05, 32'h12345678);
        send_tlp(MEMRD32, 1, 0, 8'h33, 32'h0);
        send_tlp(CPLD, 2, 0, 8'h05, 32'hCAFEF00D);
        tick(0, 0, 0);

        arm_chk(1, 8'h07, 32'hA5A5A5A5, 1);
        send_tlp(CPLD, 1, 0, 8'h08, 32'hA5A5A5A5);
        arm_chk(1, 8'h07, 32'hA5A5A5A5, 1);
        send_tlp(CPLD, 1, 3'b001, 8'h07, 32'hA5A5A5A5);
        arm_chk(1, 8'h07, 32'hA5A5A5A5, 1);
        send_tlp(CPLD, 1, 0, 8'h07, 32'hDEADBEEF);
        arm_chk(1, 8'h07, 32'hA5A5A5A5, 1);
        send_tlp(CPL, 1, 0, 8'h07, 32'hA5A5A5A5);

        arm_chk(1, 8'h11, 32'h1, 2);
        send_tlp(CPLD, 4, 0, 8'h11, 32'h1);
        arm_chk(1, 8'h11, 32'h1, 0);
        tick(0, 0, 0);

        arm_chk(1, 8'h22, 32'h2, 3);
        repeat (TMO + 3) tick(0, 0, 0);
        arm_chk(0, 8'h22, 32'h2, 3);
        repeat (TMO + 20) tick(0, 0, 0);

        arm_chk(1, 8'h09, 32'h99, 4);
        send_tlp(CPLD, 4, 0, 8'h09, 32'h99, 0);
        #2;
        reset_n = 1'b0;
        tvalid = 1'b0;
        tlast = 1'b0;
        #1;
        m_active = 0;
        m_err = 0;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_tready", {31'd0, tready}, 32'd0);
        check("rstmid_pulses", {30'd0, rx_success, rx_fail}, 32'd0);
        repeat (2) @(posedge user_clk);
        @(negedge user_clk);
        reset_n = 1'b1;
        tick(0, 0, 0);
        arm_chk(1, 8'h0A, 32'h55AA55AA, 3);
        send_tlp(CPLD, 3, 0, 8'h0A, 32'h55AA55AA);
        tick(0, 0, 0);

        for (int it = 0; it < 40; it++) begin
            arm_chk(1, 8'($urandom), $urandom, $urandom_range(1, 8));
            for (int k = 0; k < 12 && m_active; k++) begin
                r = $urandom_range(0, 9);
                rem = m_exp - m_acc;
                repeat ($urandom_range(0, 2)) tick(0, 0, 0);
                if (r == 0) begin
                    send_tlp(MEMRD32, 1, 0, 8'($urandom), $urandom);
                end else if (r == 1) begin
                    send_tlp(MEMWR32, $urandom_range(1, 6), 0,
                             8'($urandom), $urandom);
                end else if (r == 2) begin
                    c = $urandom_range(0, 4);
                    if (c == 0)
                        send_tlp(CPLD, 1, 3'($urandom_range(1, 7)),
                                 m_tag, m_data);
                    else if (c == 1)
                        send_tlp(CPLD, 1, 0, m_tag + 8'd1, m_data);
                    else if (c == 2)
                        send_tlp(CPL, 1, 0, m_tag, m_data);
                    else if (c == 3)
                        send_tlp(CPLD, 1, 0, m_tag, ~m_data);
                    else
                        send_tlp(CPLD, rem + 1, 0, m_tag, m_data);
                end else if (r == 3) begin
                    arm_chk(1, 8'($urandom), $urandom, $urandom_range(1, 8));
                end else begin
                    send_tlp(CPLD, $urandom_range(1, rem), 0, m_tag, m_data);
                end
            end
            repeat (2) tick(0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
